// File: rtl/instruction_encoder_pkg.sv
// Shared ARMAria encoding constants, FSM state type and a field-range helper.
package instruction_encoder_pkg;

  localparam int ID_W     = 7;
  localparam int REG_W    = 4;
  localparam int OFF_W    = 12;
  localparam int COND_W   = 5;
  localparam int WORD_W   = 16;

  // Decoded instruction IDs, shared with the control unit's decoder.
  localparam logic [ID_W-1:0] ID_LSL          = 7'h01;
  localparam logic [ID_W-1:0] ID_LSR          = 7'h02;
  localparam logic [ID_W-1:0] ID_ASR          = 7'h03;
  localparam logic [ID_W-1:0] ID_ADD_REG      = 7'h04;
  localparam logic [ID_W-1:0] ID_SUB_REG      = 7'h05;
  localparam logic [ID_W-1:0] ID_ADD_IMM3     = 7'h06;
  localparam logic [ID_W-1:0] ID_SUB_IMM3     = 7'h07;
  localparam logic [ID_W-1:0] ID_MOV_IMM8     = 7'h08;
  localparam logic [ID_W-1:0] ID_SUB_IMM8     = 7'h0B;
  localparam logic [ID_W-1:0] ID_ALU_FIRST    = 7'h0C;
  localparam logic [ID_W-1:0] ID_ALU_LAST     = 7'h1B;
  localparam logic [ID_W-1:0] ID_LDR_PC       = 7'h27;
  localparam logic [ID_W-1:0] ID_LS_REG_FIRST = 7'h28;
  localparam logic [ID_W-1:0] ID_LS_REG_LAST  = 7'h2F;
  localparam logic [ID_W-1:0] ID_LS_IMM_FIRST = 7'h30;
  localparam logic [ID_W-1:0] ID_LS_IMM_LAST  = 7'h35;
  localparam logic [ID_W-1:0] ID_LS_SP_FIRST  = 7'h36;
  localparam logic [ID_W-1:0] ID_LS_SP_LAST   = 7'h39;
  localparam logic [ID_W-1:0] ID_B            = 7'h48;
  localparam logic [ID_W-1:0] ID_BCOND        = 7'h49;
  localparam logic [ID_W-1:0] ID_BX           = 7'h4A;
  localparam logic [ID_W-1:0] ID_BLX          = 7'h4B;
  localparam logic [ID_W-1:0] ID_HALT         = 7'h64;

  // Major opcodes (instruction bits 15:12).
  localparam logic [3:0] OPC_LS_REG = 4'h5;
  localparam logic [3:0] OPC_LS_IMM = 4'h6;
  localparam logic [3:0] OPC_LS_SP  = 4'h9;
  localparam logic [3:0] OPC_BCOND  = 4'hD;
  localparam logic [3:0] OPC_BX     = 4'hE;
  localparam logic [7:0] OPC_B      = 8'hC0;

  // Condition code 0x0F means "always" and is not encodable in a conditional branch.
  localparam logic [COND_W-1:0] COND_ALWAYS = 5'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE,
    ST_FAULT
  } enc_state_t;

  // True when the offset has no set bits above an immediate field of the given width.
  function automatic logic offset_fits(input logic [OFF_W-1:0] off, input int unsigned bits);
    return (off >> bits) == '0;
  endfunction

endpackage

// File: rtl/instruction_packer.sv
// Pure combinational packer: decoded field tuple -> 16-bit instruction word plus an
// illegal flag for unknown IDs or fields that do not fit their encoding slot.
module instruction_packer
  import instruction_encoder_pkg::*;
(
  input  logic [ID_W-1:0]   i_id,
  input  logic [REG_W-1:0]  i_reg_d,
  input  logic [REG_W-1:0]  i_reg_a,
  input  logic [REG_W-1:0]  i_reg_b,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [COND_W-1:0] i_cond,
  output logic [WORD_W-1:0] o_word,
  output logic              o_illegal
);

  logic [2:0] w_rd, w_ra, w_rb;
  logic       w_rd_ok, w_ra_ok, w_rb_ok, w_ra_is_rd;
  logic       w_imm3_ok, w_imm5_ok, w_imm8_ok;
  logic [1:0] w_sub_rr;
  logic [3:0] w_sub_alu;
  logic [2:0] w_sub_ls;
  logic [1:0] w_sub_lsi;
  logic [3:0] w_opc_lsi, w_opc_sp;

  assign w_rd       = i_reg_d[2:0];
  assign w_ra       = i_reg_a[2:0];
  assign w_rb       = i_reg_b[2:0];
  assign w_rd_ok    = ~i_reg_d[3];
  assign w_ra_ok    = ~i_reg_a[3];
  assign w_rb_ok    = ~i_reg_b[3];
  assign w_ra_is_rd = (i_reg_a == i_reg_d);
  assign w_imm3_ok  = offset_fits(i_offset, 3);
  assign w_imm5_ok  = offset_fits(i_offset, 5);
  assign w_imm8_ok  = offset_fits(i_offset, 8);

  // Sub-opcodes are the ID's distance from the first ID of its group.
  assign w_sub_rr  = 2'(i_id - ID_ADD_REG);
  assign w_sub_alu = 4'(i_id - ID_ALU_FIRST);
  assign w_sub_ls  = 3'(i_id - ID_LS_REG_FIRST);
  assign w_sub_lsi = 2'((i_id - ID_LS_IMM_FIRST) >> 1);
  assign w_opc_lsi = OPC_LS_IMM + {2'b00, w_sub_lsi};
  // 0x36/0x37 have ID bit 1 set and use opcode 9; 0x38/0x39 use opcode 10.
  assign w_opc_sp  = OPC_LS_SP + {3'b000, ~i_id[1]};

  // Select the encoding group by ID and validate the fields that group uses.
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    if (i_id == ID_LSL || i_id == ID_LSR) begin
      o_word    = {4'b0000, i_id[1], i_offset[4:0], w_ra, w_rd};
      o_illegal = !(w_imm5_ok && w_ra_ok && w_rd_ok);
    end else if (i_id == ID_ASR) begin
      o_word    = {5'b00010, i_offset[4:0], w_ra, w_rd};
      o_illegal = !(w_imm5_ok && w_ra_ok && w_rd_ok);
    end else if (i_id >= ID_ADD_REG && i_id <= ID_SUB_IMM3) begin
      if (i_id <= ID_SUB_REG) begin
        o_word    = {5'b00011, w_sub_rr, w_rb, w_ra, w_rd};
        o_illegal = !(w_rb_ok && w_ra_ok && w_rd_ok);
      end else begin
        o_word    = {5'b00011, w_sub_rr, i_offset[2:0], w_ra, w_rd};
        o_illegal = !(w_imm3_ok && w_ra_ok && w_rd_ok);
      end
    end else if (i_id >= ID_MOV_IMM8 && i_id <= ID_SUB_IMM8) begin
      o_word    = {3'b001, i_id[1:0], w_rd, i_offset[7:0]};
      o_illegal = !(w_imm8_ok && w_rd_ok && w_ra_is_rd);
    end else if (i_id >= ID_ALU_FIRST && i_id <= ID_ALU_LAST) begin
      o_word    = {5'b01000, 1'b0, w_sub_alu, w_rb, w_rd};
      o_illegal = !(w_rb_ok && w_rd_ok && w_ra_is_rd);
    end else if (i_id == ID_LDR_PC) begin
      o_word    = {5'b01001, w_rd, i_offset[7:0]};
      o_illegal = !(w_imm8_ok && w_rd_ok);
    end else if (i_id >= ID_LS_REG_FIRST && i_id <= ID_LS_REG_LAST) begin
      o_word    = {OPC_LS_REG, w_sub_ls, w_rb, w_ra, w_rd};
      o_illegal = !(w_rb_ok && w_ra_ok && w_rd_ok);
    end else if (i_id >= ID_LS_IMM_FIRST && i_id <= ID_LS_IMM_LAST) begin
      o_word    = {w_opc_lsi, i_id[0], i_offset[4:0], w_ra, w_rd};
      o_illegal = !(w_imm5_ok && w_ra_ok && w_rd_ok);
    end else if (i_id >= ID_LS_SP_FIRST && i_id <= ID_LS_SP_LAST) begin
      o_word    = {w_opc_sp, i_id[0], w_rd, i_offset[7:0]};
      o_illegal = !(w_imm8_ok && w_rd_ok);
    end else if (i_id == ID_B) begin
      o_word    = {OPC_B, i_offset[7:0]};
      o_illegal = !w_imm8_ok;
    end else if (i_id == ID_BCOND) begin
      o_word    = {OPC_BCOND, i_cond[3:0], i_offset[7:0]};
      o_illegal = !w_imm8_ok || (i_cond >= COND_ALWAYS);
    end else if (i_id == ID_BX || i_id == ID_BLX) begin
      o_word    = {OPC_BX, i_id[0], 11'b0};
    end else if (i_id == ID_HALT) begin
      o_word    = 16'hFFFF;
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Program writer: accepts decoded tuples over valid/ready, packs them and writes
// consecutive instruction-memory words from base_addr, stopping on a sticky fault.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ID_WIDTH               = 7,
  parameter int REGISTER_WIDTH         = 4,
  parameter int OFFSET_WIDTH           = 12,
  parameter int BRANCH_CONDITION_WIDTH = 5,
  parameter int ADDR_WIDTH             = 12
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [ID_WIDTH-1:0]               ID,
  input  logic [REGISTER_WIDTH-1:0]         RegD,
  input  logic [REGISTER_WIDTH-1:0]         RegA,
  input  logic [REGISTER_WIDTH-1:0]         RegB,
  input  logic [OFFSET_WIDTH-1:0]           Offset,
  input  logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [15:0]                       mem_data,
  output logic [ADDR_WIDTH:0]               words_written,
  output logic                              done,
  output logic                              fault,
  output logic [ID_WIDTH-1:0]               fault_id
);

  enc_state_t          r_state, w_state_next;
  logic [ADDR_WIDTH:0] r_wr_ptr;      // extra MSB marks "past the last address"
  logic                r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]         r_mem_data;
  logic [ADDR_WIDTH:0] r_words;
  logic [ID_WIDTH-1:0] r_fault_id;

  logic [15:0] w_word;
  logic        w_illegal, w_accept, w_reject, w_restart;

  instruction_packer u_packer (
    .i_id      (ID),
    .i_reg_d   (RegD),
    .i_reg_a   (RegA),
    .i_reg_b   (RegB),
    .i_offset  (Offset),
    .i_cond    (branch_condition),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_accept  = in_valid && (r_state == ST_STREAM);
  assign w_reject  = w_illegal || r_wr_ptr[ADDR_WIDTH];
  assign w_restart = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_FAULT);

  // Next-state logic: start only restarts from idle/done/fault, never mid-program.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_restart) w_state_next = ST_STREAM;
      ST_STREAM: begin
        if (w_accept) begin
          if (w_reject)     w_state_next = ST_FAULT;
          else if (in_last) w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH:  w_state_next = ST_DONE;
      ST_DONE:   w_state_next = w_restart ? ST_STREAM : ST_IDLE;
      ST_FAULT:  if (w_restart) w_state_next = ST_STREAM;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Write port, address pointer, word counter and fault ID capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_words    <= '0;
      r_fault_id <= '0;
    end else begin
      r_mem_we <= w_accept && !w_reject;
      if (r_mem_we) r_words <= r_words + 1'b1;
      if (w_restart) begin
        r_wr_ptr <= {1'b0, base_addr};
        r_words  <= '0;
      end
      if (w_accept && !w_reject) begin
        r_mem_addr <= r_wr_ptr[ADDR_WIDTH-1:0];
        r_mem_data <= w_word;
        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end
      if (w_accept && w_reject) r_fault_id <= ID;
    end
  end

  assign in_ready      = (r_state == ST_STREAM);
  assign done          = (r_state == ST_DONE);
  assign fault         = (r_state == ST_FAULT);
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_data      = r_mem_data;
  assign words_written = r_words;
  assign fault_id      = r_fault_id;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Encoder/program writer for the ARMAria 16-bit ISA: accepts decoded instruction fields (ID, RegD/RegA/RegB, Offset, branch_condition) over a valid/ready stream, packs them into 16-bit instruction words and writes them to consecutive instruction-memory addresses. It is the inverse of the control unit's instruction decoder and sits between the OS/loader or self-test sequencer and the instruction memory write port. Illegal or unencodable tuples stop the stream with a sticky fault.

## Interface
- ID_WIDTH, 7, decoded instruction ID width
- REGISTER_WIDTH, 4, register index width
- OFFSET_WIDTH, 12, offset field width
- BRANCH_CONDITION_WIDTH, 5, branch condition width
- ADDR_WIDTH, 12, instruction memory address width
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse: begin program at base_addr (ignored unless IDLE/DONE/FAULT)
- base_addr  in  ADDR_WIDTH  first write address, sampled on start
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder accepts tuple this cycle
- in_last  in  1  tuple is final instruction of program
- ID, RegD, RegA, RegB, Offset, branch_condition  in  widths per parameters  decoded fields
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_WIDTH  write address
- mem_data  out  16  encoded instruction
- words_written  out  ADDR_WIDTH+1  count since start
- done  out  1  one-cycle pulse after last word written
- fault  out  1  sticky until next start/reset
- fault_id  out  ID_WIDTH  ID of rejected tuple

## Operation
- States: IDLE, STREAM, FLUSH, DONE, FAULT. start -> STREAM, address=base_addr, count=0, fault cleared.
- STREAM: in_ready=1; handshake = in_valid & in_ready. Accepted tuple encoded and registered; in_last -> FLUSH.
- Encodings (imm5=Offset[4:0], imm8=Offset[7:0], rX=RegX[2:0]):
  - ID 1/2: 0000,op,imm5,rA,rD; ID 3: 00010,imm5,rA,rD; ID 4–7: 00011,(ID-4)[1:0],rB (4,5) or imm3 (6,7),rA,rD.
  - ID 8–11: 001,ID[1],ID[0],rD,imm8 (RegA must equal RegD).
  - ID 0x0C–0x1B: 01000,(ID-0x0C)[3:2]→funct2 bits 9:8,(ID-0x0C)[1:0],rB,rD; RegA must equal RegD.
  - ID 0x27: 01001,rD,imm8. ID 0x28–0x2F: 0101,(ID-0x28)[2:0],rB,rA,rD.
  - ID 0x30–0x35: opcode 6/7/8 = 6+(ID-0x30)>>1, op=ID[0], imm5,rA,rD.
  - ID 0x36–0x39: opcode 9 (0x36/37) or 10 (0x38/39), op=ID[0], rD, imm8.
  - ID 0x48: 0xC0,imm8. ID 0x49: 1101,cond[3:0],imm8. ID 0x4A/0x4B: 1110,op,11'b0. ID 0x64: 0xFFFF.
- Fault conditions: any other ID; Offset bits above field width nonzero; RegD/RegA/RegB bit 3 set where field is 3-bit; ID 0x49 with branch_condition ≥ 0x0F; address overflow (write beyond 2^ADDR_WIDTH-1). Faulting tuple is not written; -> FAULT, fault_id latched.
- FLUSH: last word written -> DONE. DONE: done=1 one cycle -> IDLE.
- FAULT: in_ready=0, no writes, until start or reset.

## Timing
- Reset: state IDLE; in_ready, mem_we, done, fault = 0; mem_addr, mem_data, words_written, fault_id = 0.
- Latency: tuple accepted cycle N -> mem_we=1 with data/address at cycle N+1; address and count increment after each write.
- Throughput: one tuple per cycle, no back-pressure except state.
- fault asserts N+1 after accepting bad tuple; in_ready drops same edge.
- start while STREAM/FLUSH ignored. reset mid-stream: pending write discarded, state IDLE next cycle.
- Last address 0xFFF written legally; a further tuple faults (overflow).

## Structure
- Shared package: ID constants (ID_LSL=1 … ID_HALT=0x64), opcode constants, COND_ALWAYS=0x0F — shared with the decoder.
- Sub-module: instruction_packer (pure combinational tuple -> {word, illegal}); FSM, address counter and output registers in top.

## Test plan
- start base 0x800; tuples ID 2 (rD=1,rA=2,imm5=3), ID 9 (rD=3,imm8=0x7F, last) -> writes 0x08D1 @0x800, 0x2B7F @0x801, done at cycle after second write, words_written=2.
- Back-to-back 8 tuples ID 0x28–0x2F rD=1,rA=2,rB=3 -> 8 consecutive writes 0x50D1,0x52D1…0x5ED1, one per cycle.
- ID 0x49 cond=0x0F -> no write, fault=1, fault_id=0x49, in_ready=0; next start clears.
- ID 3 with Offset=0x20 -> fault; ID 0x1C -> fault (unsupported).
- base 0xFFF, two tuples ID 0x4A -> write 0xE000 @0xFFF, second tuple faults.
- reset asserted the cycle after acceptance -> no mem_we, all outputs zero next cycle.
